// File: rtl/reg_port_arbiter_pkg.sv
// Shared types and constants for the A/B/C register-port arbiter.
// Register-select encodings are shared with the register block.
package reg_port_arbiter_pkg;

  localparam int unsigned N_REQ_DEF  = 3;
  localparam int unsigned DATA_W_DEF = 19;
  localparam int unsigned SEL_W_DEF  = 2;

  localparam logic [SEL_W_DEF-1:0] LOAD_REG_A = 2'b00;
  localparam logic [SEL_W_DEF-1:0] LOAD_REG_B = 2'b01;
  localparam logic [SEL_W_DEF-1:0] LOAD_REG_C = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } arb_state_t;

  // Takes a zero-extended select so callers with any SEL_W can share it.
  function automatic logic sel_valid(input int unsigned sel);
    return (sel == 32'(LOAD_REG_A)) ||
           (sel == 32'(LOAD_REG_B)) ||
           (sel == 32'(LOAD_REG_C));
  endfunction

endpackage

// File: rtl/reg_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: one-hot winner starting at ptr_i,
// plus the pointer value that follows that winner.
module reg_port_arbiter_rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] win_o,
  output logic             any_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  // One extra bit so ptr + offset never wraps before the modulo fold.
  logic [PTR_W:0] sum;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    any_o = 1'b0;
    sum   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) begin
        sum = sum - (PTR_W+1)'(N_REQ);
      end
      if (!any_o && req_i[sum[PTR_W-1:0]]) begin
        any_o                  = 1'b1;
        gnt_o[sum[PTR_W-1:0]]  = 1'b1;
        win_o                  = sum[PTR_W-1:0];
      end
    end
  end

  assign next_ptr_o = ((32'(win_o) + 32'd1) >= N_REQ) ? '0 : win_o + PTR_W'(1);

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter for the single-ported A/B/C register block.
// Optional requester lock for atomic read-modify-write: define REG_ARB_LOCK_EN.
//
//   state   | meaning
//   IDLE    | waiting for a request; GNT driven combinationally
//   ISSUE   | select/data on the block; LOAD_REG pulses for valid writes
//   CAPTURE | read select held; REG_DATA_OUT sampled into RDATA
//   RESP    | ACK pulse to the granted requester with ERR/RDATA
module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          REQ_WR,
  input  logic [N_REQ*SEL_W-1:0]    REQ_SEL,
  input  logic [N_REQ*DATA_W-1:0]   REQ_WDATA,
`ifdef REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          REQ_LOCK,
`endif
  output logic [N_REQ-1:0]          GNT,
  output logic [N_REQ-1:0]          ACK,
  output logic                      ERR,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      LOAD_REG,
  output logic [SEL_W-1:0]          LOAD_SELECT,
  output logic [DATA_W-1:0]         REG_DATA_IN,
  input  logic [DATA_W-1:0]         REG_DATA_OUT
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic                wr_q, wr_d;
  logic                sel_ok_q, sel_ok_d;
  logic                err_q, err_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [SEL_W-1:0]    lsel_q, lsel_d;
  logic [DATA_W-1:0]   ldata_q, ldata_d;
  logic                load_reg;

  logic [N_REQ-1:0]    arb_req;
  logic [N_REQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]    arb_win;
  logic                arb_any;
  logic [PTR_W-1:0]    arb_next;

  logic                g_wr;
  logic [SEL_W-1:0]    g_sel;
  logic [DATA_W-1:0]   g_wdata;
  logic                g_sel_ok;
  logic [N_REQ-1:0]    win_onehot;

  assign win_onehot = N_REQ'(1) << win_q;

`ifdef REG_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lk_q, lk_d;

  // While locked, win_q still names the owner: nobody else can be granted.
  assign arb_req = lock_q ? (REQ & win_onehot) : REQ;
`else
  assign arb_req = REQ;
`endif

  reg_port_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i      (arb_req),
    .ptr_i      (ptr_q),
    .gnt_o      (arb_gnt),
    .win_o      (arb_win),
    .any_o      (arb_any),
    .next_ptr_o (arb_next)
  );

  always_comb begin
    g_wr    = 1'b0;
    g_sel   = '0;
    g_wdata = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (arb_gnt[i]) begin
        g_wr    = REQ_WR[i];
        g_sel   = REQ_SEL[i*SEL_W +: SEL_W];
        g_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign g_sel_ok = sel_valid(32'(g_sel));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    wr_d     = wr_q;
    sel_ok_d = sel_ok_q;
    err_d    = err_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    lsel_d   = lsel_q;
    ldata_d  = ldata_q;
    load_reg = 1'b0;
`ifdef REG_ARB_LOCK_EN
    lock_d   = lock_q;
    lk_d     = lk_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          win_d    = arb_win;
          wr_d     = g_wr;
          sel_ok_d = g_sel_ok;
          err_d    = 1'b0;
          ptr_d    = arb_next;
          state_d  = ISSUE;
          if (g_sel_ok) begin
            lsel_d  = g_sel;
            ldata_d = g_wdata;
          end
`ifdef REG_ARB_LOCK_EN
          lk_d = REQ_LOCK[arb_win];
          if (REQ_LOCK[arb_win]) begin
            ptr_d = ptr_q;
          end
`endif
        end
      end
      ISSUE: begin
        if (!sel_ok_q) begin
          err_d   = 1'b1;
          ack_d   = win_onehot;
          state_d = RESP;
        end else if (wr_q) begin
          load_reg = 1'b1;
          ack_d    = win_onehot;
          state_d  = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_d = REG_DATA_OUT;
        ack_d   = win_onehot;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
`ifdef REG_ARB_LOCK_EN
        lock_d = lk_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      wr_q     <= 1'b0;
      sel_ok_q <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      lsel_q   <= '0;
      ldata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      sel_ok_q <= sel_ok_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      lsel_q   <= lsel_d;
      ldata_q  <= ldata_d;
    end
  end

`ifdef REG_ARB_LOCK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_q <= 1'b0;
      lk_q   <= 1'b0;
    end else begin
      lock_q <= lock_d;
      lk_q   <= lk_d;
    end
  end
`endif

  // Gated by RST_N so a request held through reset never shows a grant.
  assign GNT         = (state_q == IDLE && RST_N) ? arb_gnt : '0;
  assign ACK         = ack_q;
  assign ERR         = err_q;
  assign RDATA       = rdata_q;
  assign LOAD_REG    = load_reg;
  assign LOAD_SELECT = lsel_q;
  assign REG_DATA_IN = ldata_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Scoreboard bench for reg_port_arbiter: directed scenarios then random traffic,
// checked against a transaction-level round-robin model and A/B/C register image.
module tb_reg_port_arbiter;
  import reg_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int DW = 19;
  localparam int SW = 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [N-1:0]      REQ = '0;
  logic [N-1:0]      REQ_WR = '0;
  logic [N*SW-1:0]   REQ_SEL = '0;
  logic [N*DW-1:0]   REQ_WDATA = '0;
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0]      REQ_LOCK = '0;
`endif
  logic [N-1:0]      GNT;
  logic [N-1:0]      ACK;
  logic              ERR;
  logic [DW-1:0]     RDATA;
  logic              LOAD_REG;
  logic [SW-1:0]     LOAD_SELECT;
  logic [DW-1:0]     REG_DATA_IN;
  logic [DW-1:0]     REG_DATA_OUT;

  reg_port_arbiter #(.N_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .REQ          (REQ),
    .REQ_WR       (REQ_WR),
    .REQ_SEL      (REQ_SEL),
    .REQ_WDATA    (REQ_WDATA),
`ifdef REG_ARB_LOCK_EN
    .REQ_LOCK     (REQ_LOCK),
`endif
    .GNT          (GNT),
    .ACK          (ACK),
    .ERR          (ERR),
    .RDATA        (RDATA),
    .LOAD_REG     (LOAD_REG),
    .LOAD_SELECT  (LOAD_SELECT),
    .REG_DATA_IN  (REG_DATA_IN),
    .REG_DATA_OUT (REG_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  // Register block environment (not reset by RST_N, like the real block).
  logic [DW-1:0] regs [4] = '{default: '0};
  always @(posedge CLK) begin
    if (LOAD_REG && LOAD_SELECT != 2'b11) regs[LOAD_SELECT] <= REG_DATA_IN;
  end
  assign REG_DATA_OUT = (LOAD_SELECT == 2'b11) ? '0 : regs[LOAD_SELECT];

  typedef struct {
    int          idx;
    bit          err;
    bit          rd;
    logic [DW-1:0] rdata;
    int          due;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            free_cyc = 0;
  int            load_cyc = -1;
  logic [SW-1:0] load_sel = '0;
  logic [DW-1:0] load_dat = '0;
  int            mdl_ptr = 0;
  logic [DW-1:0] mdl_mem [4] = '{default: '0};
  logic [DW-1:0] last_rdata = '0;
  int            gnt_cnt [N] = '{default: 0};
  int            seen [N] = '{default: 0};
  int            n_timeouts = 0;
  bit            done = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin : monitor
    exp_t          e;
    logic [N-1:0]  exp_g;
    logic [N-1:0]  exp_ack;
    logic [DW-1:0] exp_rd;
    logic [SW-1:0] s;
    int            w;
    bit            exp_ld;
    while (!done) begin
      @(negedge CLK);
      if (!RST_N) begin
        checks++;
        if (GNT !== '0 || ACK !== '0 || ERR !== 1'b0 || RDATA !== '0 ||
            LOAD_REG !== 1'b0 || LOAD_SELECT !== '0 || REG_DATA_IN !== '0) begin
          errors++;
          $display("FAIL reset_outputs: got gnt=%b ack=%b err=%b rdata=%h ld=%b sel=%b din=%h, want all zero",
                   GNT, ACK, ERR, RDATA, LOAD_REG, LOAD_SELECT, REG_DATA_IN);
        end
        q.delete();
        mdl_ptr    = 0;
        free_cyc   = 0;
        load_cyc   = -1;
        last_rdata = '0;
      end else begin
        cyc++;
        // register write strobe
        exp_ld = (cyc == load_cyc);
        if (exp_ld || LOAD_REG !== 1'b0) begin
          checks++;
          if (LOAD_REG !== exp_ld ||
              (exp_ld && (LOAD_SELECT !== load_sel || REG_DATA_IN !== load_dat))) begin
            errors++;
            $display("FAIL load_reg @%0d: got ld=%b sel=%b din=%h, want ld=%b sel=%b din=%h",
                     cyc, LOAD_REG, LOAD_SELECT, REG_DATA_IN, exp_ld, load_sel, load_dat);
          end
        end
        // completion
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          checks++;
          exp_ack = '0;
          exp_ack[e.idx] = 1'b1;
          exp_rd = e.rd ? e.rdata : last_rdata;
          if (ACK !== exp_ack || ERR !== e.err || RDATA !== exp_rd) begin
            errors++;
            $display("FAIL ack_resp @%0d: got ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                     cyc, ACK, ERR, RDATA, exp_ack, e.err, exp_rd);
          end
          if (e.rd) last_rdata = e.rdata;
        end else if (ACK !== '0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack @%0d: got ack=%b, want 0", cyc, ACK);
        end
        // grant
        exp_g = '0;
        w = -1;
        if (cyc >= free_cyc && REQ != '0) begin
          w = rr_pick(REQ, mdl_ptr);
          exp_g[w] = 1'b1;
        end
        if (exp_g != '0 || GNT !== '0) begin
          checks++;
          if (GNT !== exp_g) begin
            errors++;
            $display("FAIL grant @%0d: got gnt=%b, want %b (req=%b ptr=%0d)",
                     cyc, GNT, exp_g, REQ, mdl_ptr);
          end
        end
        if (w >= 0) begin
          s = REQ_SEL[w*SW +: SW];
          e.idx   = w;
          e.err   = (s != LOAD_REG_A && s != LOAD_REG_B && s != LOAD_REG_C);
          e.rd    = !e.err && !REQ_WR[w];
          e.rdata = e.rd ? mdl_mem[s] : '0;
          e.due   = cyc + (e.rd ? 3 : 2);
          if (!e.err && REQ_WR[w]) begin
            mdl_mem[s] = REQ_WDATA[w*DW +: DW];
            load_cyc   = cyc + 1;
            load_sel   = s;
            load_dat   = REQ_WDATA[w*DW +: DW];
          end
          q.push_back(e);
          free_cyc = e.due + 1;
          mdl_ptr  = (w + 1) % N;
          gnt_cnt[w]++;
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, want 0", q.size());
    end
    checks++;
    if (n_timeouts != 0) begin
      errors++;
      $display("FAIL grant_wait: got %0d grant timeouts, want 0", n_timeouts);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic issue(input int i, input bit wr, input logic [SW-1:0] sel,
                       input logic [DW-1:0] d);
    REQ[i]               = 1'b1;
    REQ_WR[i]            = wr;
    REQ_SEL[i*SW +: SW]  = sel;
    REQ_WDATA[i*DW +: DW] = d;
  endtask

  task automatic wait_gnt(input int i);
    int n = 0;
    while (gnt_cnt[i] == seen[i] && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    if (gnt_cnt[i] == seen[i]) n_timeouts++;
    seen[i] = gnt_cnt[i];
    REQ[i]  = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge CLK);
    #1;
  endtask

  initial begin : driver
    // contention held from reset: writes A=1, B=2, C=3
    issue(0, 1'b1, LOAD_REG_A, 19'd1);
    issue(1, 1'b1, LOAD_REG_B, 19'd2);
    issue(2, 1'b1, LOAD_REG_C, 19'd3);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (13) @(posedge CLK);
    #1;
    REQ = '0;
    for (int i = 0; i < N; i++) seen[i] = gnt_cnt[i];
    settle();

    // single write then read back
    issue(0, 1'b1, LOAD_REG_A, 19'h000AA);
    wait_gnt(0);
    settle();
    issue(1, 1'b1, LOAD_REG_B, 19'h000BB);
    wait_gnt(1);
    settle();
    issue(1, 1'b0, LOAD_REG_B, '0);
    wait_gnt(1);
    settle();
    issue(0, 1'b0, LOAD_REG_A, '0);
    wait_gnt(0);
    settle();

    // invalid select, then all three registers read back together
    issue(2, 1'b1, 2'b11, 19'h7FFFF);
    wait_gnt(2);
    settle();
    issue(0, 1'b0, LOAD_REG_A, '0);
    issue(1, 1'b0, LOAD_REG_B, '0);
    issue(2, 1'b0, LOAD_REG_C, '0);
    wait_gnt(0);
    wait_gnt(1);
    wait_gnt(2);
    settle();

    // reset during CAPTURE of a read
    issue(1, 1'b0, LOAD_REG_C, '0);
    wait_gnt(1);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    REQ   = '0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    issue(1, 1'b0, LOAD_REG_A, '0);
    issue(0, 1'b0, LOAD_REG_B, '0);
    wait_gnt(0);
    wait_gnt(1);
    settle();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++) begin
        if (gnt_cnt[i] != seen[i]) begin
          seen[i] = gnt_cnt[i];
          REQ[i]  = 1'b0;
        end else if (!REQ[i] && $urandom_range(0, 2) == 0) begin
          issue(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 19'($urandom));
        end
      end
    end
    REQ = '0;
    repeat (10) @(posedge CLK);
    #1 done = 1'b1;
  end

endmodule

// File: doc/reg_port_arbiter.md
Name: reg_port_arbiter

Overview:
- Arbitrates N_REQ requesters (ALU writeback, load unit, debug) for the single-ported A/B/C register block.
- Drives the block's LOAD_REG, LOAD_SELECT and data_in lines, and samples its data_out.
- Round-robin grant with a valid/accept handshake; one transaction at a time.
- Reports completion per requester with an ACK pulse, plus read data or an error flag.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_W, 19, register data width.
- SEL_W, 2, register select width; encodings LOAD_REG_A/B/C come from constants.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- REQ  in  N_REQ  per-requester request; held until GNT.
- REQ_WR  in  N_REQ  1 = write, 0 = read.
- REQ_SEL  in  N_REQ*SEL_W  packed register selects.
- REQ_WDATA  in  N_REQ*DATA_W  packed write data.
- GNT  out  N_REQ  one-hot accept, combinational, valid in IDLE only.
- ACK  out  N_REQ  one-hot registered completion pulse.
- ERR  out  1  valid with ACK; 1 = invalid select.
- RDATA  out  DATA_W  read data, valid with ACK of a read.
- LOAD_REG  out  1  to register block: write enable.
- LOAD_SELECT  out  SEL_W  to register block: register select.
- REG_DATA_IN  out  DATA_W  to register block: write data.
- REG_DATA_OUT  in  DATA_W  from register block: read data.

Behaviour:
- Reset (async, RST_N low): state IDLE, rr pointer 0 (requester 0 highest priority).
  - Outputs: GNT 0, ACK 0, ERR 0, RDATA 0, LOAD_REG 0, LOAD_SELECT 0, REG_DATA_IN 0.
  - Any in-flight transaction is dropped; no ACK is issued for it.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any REQ is high, the round-robin winner w gets GNT[w]=1 in that cycle.
  - Its wr/sel/wdata are latched and the state moves to ISSUE; the requester may drop REQ after GNT.
  - The pointer advances to w+1 mod N_REQ on grant.
- ISSUE, valid sel: LOAD_SELECT=sel and REG_DATA_IN=wdata.
  - Write: LOAD_REG=1 for exactly this cycle, then RESP.
  - Read: LOAD_REG=0, then CAPTURE.
- ISSUE, invalid sel (not A/B/C): LOAD_REG stays 0; ERR latched to 1; go to RESP.
- CAPTURE: LOAD_SELECT held; REG_DATA_OUT sampled into RDATA at the end of the cycle; go to RESP.
- RESP: ACK[w]=1 for one cycle, with ERR and RDATA valid.
  - Next state is IDLE, so a new GNT can occur the cycle after ACK.
  - RDATA holds its value until the next read capture.
  - RDATA is unchanged for writes and errors.
- LOAD_SELECT holds its last value outside ISSUE/CAPTURE; LOAD_REG is 0 outside ISSUE.
- Latency from GNT at cycle t: write ACK at t+2; read ACK at t+3; error ACK at t+2.
- Simultaneous requests: strict round-robin from the pointer; a requester with REQ continuously high is granted within N_REQ transactions.
- REQ changes outside IDLE are ignored.

Optional Feature:
- Macro REG_ARB_LOCK_EN.
- When defined:
  - Adds input REQ_LOCK [N_REQ].
  - If REQ_LOCK[w] was high at grant, only w may be granted after RESP, giving an atomic read-modify-write.
  - The pointer does not advance.
  - The lock releases when w completes a transaction granted with REQ_LOCK[w]=0, or on reset.
  - A locked requester that drops REQ leaves IDLE waiting; there is no timeout.
- When undefined: no port, pure round-robin.

Decomposition:
- Constants package additions:
  - arb_state_t enum {IDLE, ISSUE, CAPTURE, RESP}.
  - Default N_REQ.
  - Reuse the existing LOAD_REG_A/B/C encodings.
  - Helper function sel_valid().
- Sub-module rr_arbiter: combinational pick of the one-hot winner from REQ and the pointer, plus the next pointer value. It is instanced once.

Test Plan:
- Single write: REQ[0] wr sel=A wdata=19'h000AA → GNT[0] at t, LOAD_REG=1 LOAD_SELECT=A at t+1, ACK[0] ERR=0 at t+2; a later read of A gives RDATA=19'h000AA.
- Read latency: B=19'h000BB preloaded, REQ[1] read sel=B → LOAD_REG=0 throughout, ACK[1] at t+3 with RDATA=19'h000BB.
- Contention: REQ[2:0]=3'b111 held from reset with writes A=1, B=2, C=3 → grant order 0,1,2,0; ACK spacing 3 cycles; no starvation.
- Invalid select: REQ[2] write sel=2'b11 data 19'h7FFFF → ERR=1 with ACK[2] at t+2; LOAD_REG never 1; A/B/C unchanged.
- Reset mid-read: RST_N low during CAPTURE → all outputs 0 immediately, no ACK; after release, REQ[1], REQ[0] both high → GNT[0] first.
- Lock (REG_ARB_LOCK_EN): REQ[1] locked read of C, then unlocked write C=19'h00011, while REQ[0] is high → both of requester 1's transactions complete before GNT[0].
